// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared sample width and DAC serialiser state encoding
package bpsk_pkg;
  localparam int SAMPLE_W = 16;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} spi_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two circular sample buffer with occupancy flags
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rp];
  // storage array, written only when there is room
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(wr);
      rp  <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/bpsk_dac_spi.sv
// bpsk_dac_spi: buffers BPSK samples and serialises them MSB-first to an SPI DAC
module bpsk_dac_spi
  import bpsk_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                sclk,
  output logic                cs_n,
  output logic                sdata,
  output logic                frame_done,
  output logic                overflow
);
  spi_state_t state;
  logic [SAMPLE_W-1:0] head, shreg, conv;
  logic [7:0] div;
  logic [3:0] bits;
  logic full, empty, push, pop, last_div;
  assign sample_ready = !full;
  assign push         = sample_valid && !full;
  assign last_div     = div == 8'(CLK_DIV - 1);
  assign pop          = !empty && (state == IDLE || (state == GAP && last_div));
  assign conv         = head ^ {OFFSET_BIN, {(SAMPLE_W-1){1'b0}}};
  // the register drains to zero after 16 shifts, so sdata idles low with no extra logic
  assign sdata        = shreg[SAMPLE_W-1];

  sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wdata (sample_in),
    .push  (push),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // frame sequencer: load on pop, shift on sclk falling edges, hold cs_n high through the gap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      div        <= '0;
      bits       <= '0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sample_valid && full) overflow <= 1'b1;
      if (pop) begin
        state <= LOAD;
        cs_n  <= 1'b0;
        shreg <= conv;
        div   <= '0;
        bits  <= '0;
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          LOAD: begin
            state <= SHIFT;
            div   <= '0;
          end
          SHIFT: begin
            div <= last_div ? '0 : div + 8'd1;
            if (last_div) begin
              sclk <= !sclk;
              if (sclk) begin
                shreg <= shreg << 1;
                bits  <= bits + 4'd1;
                if (bits == 4'd15) begin
                  state      <= GAP;
                  cs_n       <= 1'b1;
                  frame_done <= 1'b1;
                end
              end
            end
          end
          GAP: begin
            div <= last_div ? '0 : div + 8'd1;
            if (last_div) state <= IDLE;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_bpsk_dac_spi.sv
// tb_bpsk_dac_spi: scoreboard bench driving three parameterisations of the DAC serialiser
module tb_bpsk_dac_spi;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] valid;
  logic [15:0] din [3];
  logic [2:0] ready, sclk, cs, sd, fd, ovf;
  logic [17:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  int per [3] = '{67, 67, 34};
  logic [15:0] cap [3];
  int edges [3];
  int last_fall [3];
  logic [2:0] ps, pc;
  logic [15:0] d6 [8] = '{16'h0000, 16'h1111, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0F0F, 16'hC001, 16'h5AA5};
  logic [15:0] e6 [8] = '{16'h8000, 16'h9111, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h8F0F, 16'h4001, 16'hDAA5};

  bpsk_dac_spi #(.CLK_DIV(2), .FIFO_DEPTH(4), .OFFSET_BIN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .sample_in(din[0]), .sample_valid(valid[0]), .sample_ready(ready[0]),
    .sclk(sclk[0]), .cs_n(cs[0]), .sdata(sd[0]), .frame_done(fd[0]), .overflow(ovf[0]));
  bpsk_dac_spi #(.CLK_DIV(2), .FIFO_DEPTH(4), .OFFSET_BIN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .sample_in(din[1]), .sample_valid(valid[1]), .sample_ready(ready[1]),
    .sclk(sclk[1]), .cs_n(cs[1]), .sdata(sd[1]), .frame_done(fd[1]), .overflow(ovf[1]));
  bpsk_dac_spi #(.CLK_DIV(1), .FIFO_DEPTH(4), .OFFSET_BIN(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .sample_in(din[2]), .sample_valid(valid[2]), .sample_ready(ready[2]),
    .sclk(sclk[2]), .cs_n(cs[2]), .sdata(sd[2]), .frame_done(fd[2]), .overflow(ovf[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs(input int i, input logic v);
    int n = 0;
    while (cs[i] !== v && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cs_bound", int'(n < 500), 1);
  endtask

  // DAC model and scoreboard: capture on sclk rising while selected, compare at deselect
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        cap[i] = '0;
        edges[i] = 0;
        last_fall[i] = -1;
      end else begin
        if (!cs[i] && sclk[i] && !ps[i]) begin
          cap[i] = {cap[i][14:0], sd[i]};
          edges[i]++;
        end
        if (!cs[i] && pc[i]) begin
          if (last_fall[i] >= 0 && cyc - last_fall[i] < 100) chk("frame_period", cyc - last_fall[i], per[i]);
          last_fall[i] = cyc;
        end
        if (fd[i]) chk("frame_done_alignment", int'(cs[i] && !pc[i]), 1);
        if (cs[i] && !pc[i]) begin
          frames++;
          chk("frame_done_at_end", int'(fd[i]), 1);
          chk("sclk_rising_edges", edges[i], 16);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected none", cap[i]);
          end else chk("capture", int'({i[1:0], cap[i]}), int'(exp_q.pop_front()));
          cap[i] = '0;
          edges[i] = 0;
        end
      end
      ps[i] = sclk[i];
      pc[i] = cs[i];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sent;
    int low;
    rst_n = 1'b0;
    valid = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    idle(3);
    chk("rst_cs_n", int'(cs), 7);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_sdata", int'(sd), 0);
    chk("rst_frame_done", int'(fd), 0);
    chk("rst_overflow", int'(ovf), 0);
    chk("rst_ready", int'(ready), 7);
    rst_n = 1'b1;
    idle(3);
    // single frame: latency and frame_done timing
    @(negedge clk);
    valid[0] = 1'b1;
    din[0] = 16'h8001;
    exp_q.push_back({2'd0, 16'h0001});
    @(negedge clk);
    valid[0] = 1'b0;
    chk("cs_after_1", int'(cs[0]), 1);
    @(negedge clk);
    chk("cs_after_2", int'(cs[0]), 0);
    chk("load_sclk", int'(sclk[0]), 0);
    chk("load_sdata", int'(sd[0]), 0);
    n = 0;
    while (!fd[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_latency", n, 65);
    idle(100);
    // back-to-back frames with a two-cycle gap
    @(negedge clk);
    valid[0] = 1'b1;
    din[0] = 16'h7FFF;
    exp_q.push_back({2'd0, 16'hFFFF});
    @(negedge clk);
    din[0] = 16'h0000;
    exp_q.push_back({2'd0, 16'h8000});
    @(negedge clk);
    valid[0] = 1'b0;
    wait_cs(0, 1'b0);
    wait_cs(0, 1'b1);
    n = 0;
    while (cs[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("gap_high_cycles", n, 2);
    idle(100);
    // pass-through instance
    @(negedge clk);
    valid[1] = 1'b1;
    din[1] = 16'hA5C3;
    exp_q.push_back({2'd1, 16'hA5C3});
    @(negedge clk);
    valid[1] = 1'b0;
    idle(100);
    // hold valid for 10 cycles: five accepted then overflow
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("ready_hold", int'(ready[0]), int'(k < 5));
      valid[0] = 1'b1;
      din[0] = 16'(k + 1);
      if (k < 5) exp_q.push_back({2'd0, 16'(k + 1) ^ 16'h8000});
    end
    @(negedge clk);
    valid[0] = 1'b0;
    chk("overflow_set", int'(ovf[0]), 1);
    idle(420);
    chk("overflow_sticky", int'(ovf[0]), 1);
    chk("ready_after_drain", int'(ready[0]), 1);
    // reset in the middle of a frame with a second sample queued
    @(negedge clk);
    valid[0] = 1'b1;
    din[0] = 16'h1234;
    @(negedge clk);
    din[0] = 16'h5678;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_cs(0, 1'b0);
    idle(30);
    chk("pre_reset_cs_low", int'(cs[0]), 0);
    chk("pre_reset_ready_full_not", int'(ready[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", int'(cs[0]), 1);
    chk("abort_sclk", int'(sclk[0]), 0);
    chk("abort_ready", int'(ready[0]), 1);
    chk("abort_frame_done", int'(fd[0]), 0);
    chk("abort_overflow", int'(ovf[0]), 0);
    idle(3);
    rst_n = 1'b1;
    low = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (!cs[0] || fd[0]) low++;
    end
    chk("no_frame_after_reset", low, 0);
    // CLK_DIV=1 streaming with a full FIFO
    sent = 0;
    n = 0;
    while (sent < 8 && n < 1000) begin
      @(negedge clk);
      n++;
      if (ready[2]) begin
        valid[2] = 1'b1;
        din[2] = d6[sent];
        exp_q.push_back({2'd2, e6[sent]});
        sent++;
      end else valid[2] = 1'b0;
    end
    @(negedge clk);
    valid[2] = 1'b0;
    chk("stream_sent", sent, 8);
    chk("stream_full_seen", int'(n > 8), 1);
    idle(8 * 34 + 50);
    chk("stream_no_overflow", int'(ovf[2]), 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("frames_total", frames, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpsk_dac_spi.md
BPSK_DAC_SPI -- requirements
Module: bpsk_dac_spi

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning sample FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter OFFSET_BIN, default 1, meaning: 1 converts two's-complement input to offset binary by inverting bit 15; 0 passes samples unchanged.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-005 clk  input  1  system clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sample_in  input  16  two's-complement BPSK sample from the modulator datapath.
REQ-008 sample_valid  input  1  sample_in is valid this cycle.
REQ-009 sample_ready  output  1  FIFO can accept a sample; equals not-full.
REQ-010 sclk  output  1  DAC serial clock; idles low.
REQ-011 cs_n  output  1  DAC chip select, active low.
REQ-012 sdata  output  1  DAC serial data, MSB first.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each 16-bit frame.
REQ-014 overflow  output  1  sticky flag: a sample was offered while full.

Function
REQ-015 A sample SHALL be written to the FIFO on any cycle where sample_valid and sample_ready are both 1.
REQ-016 sample_ready SHALL depend only on FIFO occupancy; a pop in the same cycle SHALL NOT raise ready while the FIFO is full (no bypass).
REQ-017 sample_valid while sample_ready=0 SHALL drop the sample and set overflow; overflow SHALL clear only on reset.
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT, and GAP.
REQ-019 IDLE->LOAD when the FIFO is non-empty; otherwise stay in IDLE with cs_n=1, sclk=0, sdata=0.
REQ-020 LOAD (1 cycle) SHALL pop the FIFO head into a 16-bit shift register (with the OFFSET_BIN conversion applied), drive cs_n=0 and sdata=bit15, and keep sclk=0.
REQ-021 SHIFT SHALL toggle sclk every CLK_DIV cycles.
REQ-022 SHIFT SHALL shift the register left on each sclk falling edge, so sdata is stable around each rising edge.
REQ-023 SHIFT SHALL last exactly 16 sclk periods (32*CLK_DIV cycles) and end with sclk=0.
REQ-024 SHIFT->GAP after the 16th falling edge; on entering GAP, cs_n=1, sdata=0, and frame_done pulses for one cycle.
REQ-025 GAP SHALL hold cs_n=1 for CLK_DIV cycles, then go to IDLE.
REQ-026 Frame period SHALL be 1+33*CLK_DIV cycles (67 at default); back-to-back frames SHALL occur with no IDLE cycle when the FIFO is non-empty at the end of GAP.
REQ-027 Latency from a push into an empty FIFO in IDLE to cs_n falling SHALL be 2 cycles.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a push and a pop in the same cycle when the FIFO is neither empty nor full SHALL keep the occupancy unchanged.

Reset
REQ-029 While rst_n=0, outputs SHALL be: cs_n=1, sclk=0, sdata=0, frame_done=0, overflow=0, sample_ready=1.
REQ-030 Reset SHALL also empty the FIFO, put the FSM in IDLE, and clear the divider and bit counters.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately and discard it, with no frame_done pulse.
REQ-032 The first frame after reset deassertion SHALL start only from a newly pushed sample.

Structure
REQ-033 Shared package bpsk_pkg SHALL hold SAMPLE_W=16 and the spi_state_t enum (IDLE, LOAD, SHIFT, GAP).
REQ-034 The FIFO SHALL be a separate sub-module, sample_fifo (parameters WIDTH and DEPTH; outputs full and empty), instantiated once; the FSM, divider and shift register SHALL live in bpsk_dac_spi.

Verification
REQ-035 Push 0x8001 with OFFSET_BIN=1 and CLK_DIV=2 -> cs_n falls 2 cycles later; the DAC model captures 0x0001 on rising edges; frame_done pulses 65 cycles after LOAD.
REQ-036 Push 0x7FFF then 0x0000 back-to-back -> frames capture 0xFFFF then 0x8000; cs_n is high for exactly 2 cycles between the frames.
REQ-037 With OFFSET_BIN=0, push 0xA5C3 -> captured 0xA5C3; exactly 16 sclk rising edges occur while cs_n=0.
REQ-038 Hold sample_valid=1 for 10 cycles starting from IDLE -> 5 samples accepted (4 in the FIFO plus 1 popped into LOAD), sample_ready falls, overflow=1 and stays 1.
REQ-039 Assert rst_n=0 at bit 7 of a frame -> cs_n=1, sclk=0, and sample_ready=1 asynchronously; no frame_done pulse; the FIFO is empty after release.
REQ-040 CLK_DIV=1 with a continuously full FIFO -> frame period is exactly 34 cycles and no sample is dropped or reordered.
